// File: rtl/phys_free_list_pkg.sv
// Shared constants, tag type and helpers for the physical register free list.
package phys_free_list_pkg;

  localparam int unsigned FL_PHY_REGS     = 64;
  localparam int unsigned FL_ARCH_REGS    = 32;
  localparam int unsigned FL_PHY_WIDTH    = $clog2(FL_PHY_REGS);
  localparam int unsigned FREE_LIST_DEPTH = FL_PHY_REGS - FL_ARCH_REGS;
  localparam int unsigned FL_PTR_W        = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned FL_CNT_W        = FL_PTR_W + 1;

  typedef logic [FL_PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [FL_PTR_W-1:0]     fl_ptr_t;
  typedef logic [FL_CNT_W-1:0]     fl_cnt_t;

  // Population count of a two-slot request vector.
  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return 2'(v[0]) + 2'(v[1]);
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: two grants per cycle to rename,
// two releases per cycle from commit, single-cycle rollback on flush.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [1:0] alloc_valid,
  output phy_tag_t   rd_phy_new_0,
  output phy_tag_t   rd_phy_new_1,
  output logic       alloc_ready,
  output fl_cnt_t    free_count,
  input  logic [1:0] commit_alloc,
  input  logic [1:0] retire_valid,
  input  phy_tag_t   retire_phy_0,
  input  phy_tag_t   retire_phy_1,
  output logic       overflow_err
);

  phy_tag_t entry_q [FREE_LIST_DEPTH];
  phy_tag_t entry_d [FREE_LIST_DEPTH];
  fl_ptr_t  head_q, head_d;
  fl_ptr_t  tail_q, tail_d;
  fl_ptr_t  commit_head_q, commit_head_d;
  fl_cnt_t  free_count_q, free_count_d;
  fl_cnt_t  commit_count_q, commit_count_d;
  logic     overflow_q, overflow_d;

  logic       acc0, acc1, rel_drop, take;
  logic [1:0] n_a, n_c, n_f;

  // Zero-latency grant path; a lone slot-1 request sees entry[head].
  assign rd_phy_new_0 = entry_q[head_q];
  assign rd_phy_new_1 = entry_q[head_q + FL_PTR_W'(alloc_valid[0])];
  assign alloc_ready  = (free_count_q >= FL_CNT_W'(2));
  assign free_count   = free_count_q;
  assign overflow_err = overflow_q;

  // Release acceptance: tag 0 is never returned; a full queue drops the release.
  always_comb begin
    acc0     = retire_valid[0] && (retire_phy_0 != '0) &&
               (free_count_q < FL_CNT_W'(FREE_LIST_DEPTH));
    acc1     = retire_valid[1] && (retire_phy_1 != '0) &&
               ((free_count_q + FL_CNT_W'(acc0)) < FL_CNT_W'(FREE_LIST_DEPTH));
    rel_drop = (retire_valid[0] && (retire_phy_0 != '0) && !acc0) ||
               (retire_valid[1] && (retire_phy_1 != '0) && !acc1);
    n_f      = 2'(acc0) + 2'(acc1);
  end

  // Next-state for ring contents, pointers and counters.
  always_comb begin
    entry_d        = entry_q;
    n_a            = popcnt2(alloc_valid);
    n_c            = popcnt2(commit_alloc);
    take           = alloc_ready && !flush;
    if (acc0) entry_d[tail_q] = retire_phy_0;
    if (acc1) entry_d[tail_q + FL_PTR_W'(acc0)] = retire_phy_1;
    tail_d         = tail_q + FL_PTR_W'(n_f);
    commit_head_d  = commit_head_q + FL_PTR_W'(n_c);
    commit_count_d = commit_count_q + FL_CNT_W'(n_f) - FL_CNT_W'(n_c);
    head_d         = head_q;
    free_count_d   = free_count_q + FL_CNT_W'(n_f);
    if (flush) begin
      head_d       = commit_head_d;
      free_count_d = commit_count_d;
    end else if (take) begin
      head_d       = head_q + FL_PTR_W'(n_a);
      free_count_d = free_count_q - FL_CNT_W'(n_a) + FL_CNT_W'(n_f);
    end
    overflow_d     = overflow_q | rel_drop;
  end

  // State registers; reset fills the ring with the unmapped tags in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
        entry_q[i] <= FL_PHY_WIDTH'(FL_ARCH_REGS + i);
      end
      head_q         <= '0;
      tail_q         <= '0;
      commit_head_q  <= '0;
      free_count_q   <= FL_CNT_W'(FREE_LIST_DEPTH);
      commit_count_q <= FL_CNT_W'(FREE_LIST_DEPTH);
      overflow_q     <= 1'b0;
    end else begin
      entry_q        <= entry_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      commit_head_q  <= commit_head_d;
      free_count_q   <= free_count_d;
      commit_count_q <= commit_count_d;
      overflow_q     <= overflow_d;
    end
  end

  // A release into a full queue means the tag accounting upstream is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !rel_drop);

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: queue-based free/speculative model plus grant scoreboard.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] alloc_valid = '0;
  logic [1:0] commit_alloc = '0;
  logic [1:0] retire_valid = '0;
  phy_tag_t   retire_phy_0 = '0;
  phy_tag_t   retire_phy_1 = '0;
  phy_tag_t   rd_phy_new_0, rd_phy_new_1;
  logic       alloc_ready, overflow_err;
  fl_cnt_t    free_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       slot;
    phy_tag_t tag;
  } exp_t;

  exp_t     exp_q[$];
  phy_tag_t free_m[$];
  phy_tag_t spec_m[$];

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .rd_phy_new_0 (rd_phy_new_0),
    .rd_phy_new_1 (rd_phy_new_1),
    .alloc_ready  (alloc_ready),
    .free_count   (free_count),
    .commit_alloc (commit_alloc),
    .retire_valid (retire_valid),
    .retire_phy_0 (retire_phy_0),
    .retire_phy_1 (retire_phy_1),
    .overflow_err (overflow_err)
  );

  task automatic model_reset();
    free_m.delete();
    spec_m.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) free_m.push_back(phy_tag_t'(32 + i));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0; alloc_valid = '0; commit_alloc = '0; retire_valid = '0;
    retire_phy_0 = '0; retire_phy_1 = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  // Drive one cycle's inputs and record the grants the model expects.
  task automatic apply(input logic [1:0] av, input logic [1:0] ca, input logic [1:0] rv,
                       input phy_tag_t r0, input phy_tag_t r1, input logic fl);
    exp_t e;
    alloc_valid = av; commit_alloc = ca; retire_valid = rv;
    retire_phy_0 = r0; retire_phy_1 = r1; flush = fl;
    #1;
    if (!fl && free_m.size() >= 2) begin
      if (av[0]) begin e.slot = 0; e.tag = free_m[0]; exp_q.push_back(e); end
      if (av[1]) begin e.slot = 1; e.tag = free_m[av[0] ? 1 : 0]; exp_q.push_back(e); end
    end
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic step();
    int       sz;
    bit       rdy;
    int       na, nc;
    phy_tag_t rel[$];
    @(posedge clk); #1;
    sz  = free_m.size();
    rdy = (sz >= 2);
    na  = int'(alloc_valid[0]) + int'(alloc_valid[1]);
    nc  = int'(commit_alloc[0]) + int'(commit_alloc[1]);
    if (retire_valid[0] && retire_phy_0 != '0 && sz < 32) rel.push_back(retire_phy_0);
    if (retire_valid[1] && retire_phy_1 != '0 && sz + rel.size() < 32) rel.push_back(retire_phy_1);
    repeat (nc) void'(spec_m.pop_front());
    if (flush) begin
      free_m = {spec_m, free_m};
      spec_m.delete();
    end else if (rdy) begin
      repeat (na) spec_m.push_back(free_m.pop_front());
    end
    foreach (rel[i]) free_m.push_back(rel[i]);
    flush = 1'b0; alloc_valid = '0; commit_alloc = '0; retire_valid = '0;
    retire_phy_0 = '0; retire_phy_1 = '0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_phy_new_0 !== 6'd32) begin errors++; $display("FAIL reset_rd0 got %0d exp 32", rd_phy_new_0); end
    checks++; if (rd_phy_new_1 !== 6'd32) begin errors++; $display("FAIL reset_rd1 got %0d exp 32", rd_phy_new_1); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
  endtask

  task automatic test_alloc_pair();
    exp_t e; phy_tag_t got;
    do_reset();
    apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); got = (e.slot == 0) ? rd_phy_new_0 : rd_phy_new_1;
      checks++; if (got !== e.tag) begin errors++; $display("FAIL pair_grant slot%0d got %0d exp %0d", e.slot, got, e.tag); end
    end
    checks++; if (rd_phy_new_1 !== 6'd33) begin errors++; $display("FAIL pair_rd1 got %0d exp 33", rd_phy_new_1); end
    step();
    checks++; if (rd_phy_new_0 !== 6'd34) begin errors++; $display("FAIL pair_next got %0d exp 34", rd_phy_new_0); end
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL pair_count got %0d exp 30", free_count); end
  endtask

  task automatic test_lone_slot1();
    exp_t e; phy_tag_t got;
    do_reset();
    apply(2'b10, 2'b00, 2'b00, '0, '0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); got = (e.slot == 0) ? rd_phy_new_0 : rd_phy_new_1;
      checks++; if (got !== e.tag) begin errors++; $display("FAIL lone_grant slot%0d got %0d exp %0d", e.slot, got, e.tag); end
    end
    step();
    checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL lone_count got %0d exp 31", free_count); end
    checks++; if (rd_phy_new_0 !== 6'd33) begin errors++; $display("FAIL lone_head got %0d exp 33", rd_phy_new_0); end
  endtask

  task automatic test_drain();
    exp_t e; phy_tag_t got;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      apply((c == 15) ? 2'b01 : 2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = (e.slot == 0) ? rd_phy_new_0 : rd_phy_new_1;
        checks++; if (got !== e.tag) begin errors++; $display("FAIL drain_grant c%0d slot%0d got %0d exp %0d", c, e.slot, got, e.tag); end
      end
      step();
    end
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL drain_count got %0d exp 1", free_count); end
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %0b exp 0", alloc_ready); end
    apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    step();
    checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", free_count); end
    checks++; if (rd_phy_new_0 !== 6'd63) begin errors++; $display("FAIL drop_head got %0d exp 63", rd_phy_new_0); end
  endtask

  task automatic test_alloc_release();
    exp_t e; phy_tag_t got;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      if (c == 1) apply(2'b11, 2'b00, 2'b11, 6'd5, 6'd7, 1'b0);
      else        apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
      if (c == 16) begin
        checks++; if (rd_phy_new_0 !== 6'd5 || rd_phy_new_1 !== 6'd7) begin
          errors++; $display("FAIL wrap_tags got %0d/%0d exp 5/7", rd_phy_new_0, rd_phy_new_1);
        end
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); got = (e.slot == 0) ? rd_phy_new_0 : rd_phy_new_1;
        checks++; if (got !== e.tag) begin errors++; $display("FAIL rel_grant c%0d slot%0d got %0d exp %0d", c, e.slot, got, e.tag); end
      end
      step();
      if (c == 1) begin
        checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL rel_count got %0d exp 30", free_count); end
      end
    end
    checks++; if (free_count !== fl_cnt_t'(free_m.size())) begin errors++; $display("FAIL rel_final got %0d exp %0d", free_count, free_m.size()); end
  endtask

  task automatic test_flush();
    exp_t e; phy_tag_t got;
    do_reset();
    repeat (3) begin apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0); exp_q.delete(); step(); end
    apply(2'b00, 2'b11, 2'b00, '0, '0, 1'b0);
    step();
    apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b1);
    step();
    checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL flush_count got %0d exp 30", free_count); end
    checks++; if (rd_phy_new_0 !== 6'd34) begin errors++; $display("FAIL flush_head got %0d exp 34", rd_phy_new_0); end
    apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); got = (e.slot == 0) ? rd_phy_new_0 : rd_phy_new_1;
      checks++; if (got !== e.tag) begin errors++; $display("FAIL flush_grant slot%0d got %0d exp %0d", e.slot, got, e.tag); end
    end
    step();
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    repeat (2) begin apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0); exp_q.delete(); step(); end
    apply(2'b11, 2'b01, 2'b01, 6'd9, '0, 1'b1);
    step();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL fsc_count got %0d exp 32", free_count); end
    checks++; if (rd_phy_new_0 !== 6'd33) begin errors++; $display("FAIL fsc_head got %0d exp 33", rd_phy_new_0); end
    checks++; if (free_count !== fl_cnt_t'(free_m.size())) begin errors++; $display("FAIL fsc_model got %0d exp %0d", free_count, free_m.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) begin apply(2'b11, 2'b00, 2'b00, '0, '0, 1'b0); exp_q.delete(); step(); end
    checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL ar_pre got %0d exp 28", free_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ar_count got %0d exp 32", free_count); end
    checks++; if (rd_phy_new_0 !== 6'd32) begin errors++; $display("FAIL ar_head got %0d exp 32", rd_phy_new_0); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    step();
    checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL ar_hold got %0d exp 32", free_count); end
  endtask

  initial begin
    test_reset();
    test_alloc_pair();
    test_lone_slot1();
    test_drain();
    test_alloc_release();
    test_flush();
    test_flush_same_cycle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
